// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO (slave) and the
// receiver/consumer side (master).
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_done;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_overflow;
  logic              i_clr_overflow;
  logic [7:0]        o_drop_cnt;
  logic              o_afull;

  modport slave (
    input  i_rx_data, i_rx_done, i_ready, i_clr_overflow,
    output o_data, o_valid, o_count, o_full, o_empty, o_overflow, o_drop_cnt, o_afull
  );

  modport master (
    output i_rx_data, i_rx_done, i_ready, i_clr_overflow,
    input  o_data, o_valid, o_count, o_full, o_empty, o_overflow, o_drop_cnt, o_afull
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver, with overflow/drop tracking.
// Define UART_RX_FIFO_WATERMARK_EN to build the registered almost-full flag.
module uart_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic            i_Clk,
  input  logic            i_reset_n,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_param_check
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              done_q;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              full;
  logic              empty;
  logic              wr_req;
  logic              pop;
  logic              push;
  logic              drop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign wr_req = bus.i_rx_done & ~done_q;
  assign pop    = ~empty & bus.i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push   = wr_req & (~full | pop);
  assign drop   = wr_req & full & ~pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + COUNT_ONE;
    end else if (pop && !push) begin
      count_nxt = count - COUNT_ONE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_rx_data;
    end
  end

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done_q <= bus.i_rx_done;
      count  <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A drop coinciding with a clear restarts the tally at one.
      if (drop) begin
        overflow <= 1'b1;
        if (bus.i_clr_overflow) begin
          drop_cnt <= 8'd1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (bus.i_clr_overflow) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] AFULL_COUNT = (ADDR_W+1)'(AFULL_LEVEL);
  logic afull_q;

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (count_nxt >= AFULL_COUNT);
    end
  end

  assign bus.o_afull = afull_q;
`else
  logic unused_afull_level;
  assign unused_afull_level = ^AFULL_LEVEL;
  assign bus.o_afull        = 1'b0;
`endif

  assign bus.o_data     = mem[rd_ptr];
  assign bus.o_valid    = ~empty;
  assign bus.o_count    = count;
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_overflow = overflow;
  assign bus.o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int AFULL_LEVEL = 12;

  logic i_Clk;
  logic i_reset_n;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_LEVEL(AFULL_LEVEL)
  ) dut (
    .i_Clk(i_Clk),
    .i_reset_n(i_reset_n),
    .bus(bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stored bytes in arrival order plus the sticky drop state.
  logic [DATA_W-1:0] byte_q [$];
  bit                m_overflow;
  int                m_drop;
  bit                m_prev_done;

  function automatic bit exp_afull();
`ifdef UART_RX_FIFO_WATERMARK_EN
    return byte_q.size() >= AFULL_LEVEL;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    byte_q.delete();
    m_overflow  = 1'b0;
    m_drop      = 0;
    m_prev_done = 1'b0;
  endfunction

  // Advance the model with the inputs currently applied, then cross one rising edge.
  task automatic tick();
    bit rise;
    rise = bus.i_rx_done && !m_prev_done;
    if (byte_q.size() != 0 && bus.i_ready) void'(byte_q.pop_front());
    if (bus.i_clr_overflow) begin
      m_overflow = 1'b0;
      m_drop     = 0;
    end
    if (rise) begin
      if (byte_q.size() < DEPTH) begin
        byte_q.push_back(bus.i_rx_data);
      end else begin
        m_overflow = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_prev_done = bus.i_rx_done;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic write_byte(input logic [DATA_W-1:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.i_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    bus.i_rx_data      = '0;
    bus.i_rx_done      = 1'b0;
    bus.i_ready        = 1'b0;
    bus.i_clr_overflow = 1'b0;
    i_reset_n          = 1'b0;
    repeat (2) @(posedge i_Clk);
    #3;
    i_reset_n = 1'b1;
    @(posedge i_Clk);
    #1;
    n_checks++;
    if ({bus.o_valid, bus.o_empty, bus.o_full, bus.o_count, bus.o_overflow, bus.o_drop_cnt, bus.o_afull}
        !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL reset_state: valid=%b empty=%b full=%b count=%0d ovf=%b drop=%0d afull=%b, expected 0 1 0 0 0 0 0",
               bus.o_valid, bus.o_empty, bus.o_full, bus.o_count, bus.o_overflow, bus.o_drop_cnt, bus.o_afull);
    end
  endtask

  task automatic test_single_write();
    bus.i_rx_data = 8'hA5;
    bus.i_rx_done = 1'b1;
    tick();
    n_checks++;
    if ({bus.o_valid, bus.o_data, bus.o_count, bus.o_empty} !== {1'b1, 8'hA5, 5'd1, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL single_write: valid=%b data=%h count=%0d empty=%b, expected 1 a5 1 0",
               bus.o_valid, bus.o_data, bus.o_count, bus.o_empty);
    end
    bus.i_rx_done = 1'b0;
    drain();
  endtask

  task automatic test_held_done();
    bus.i_rx_data = 8'h3C;
    bus.i_rx_done = 1'b1;
    repeat (5) tick();
    bus.i_rx_done = 1'b0;
    tick();
    n_checks++;
    if ({bus.o_count, bus.o_data} !== {5'd1, 8'h3C}) begin
      n_errors++;
      $display("[TB] FAIL held_done: count=%0d data=%h, expected 1 3c", bus.o_count, bus.o_data);
    end
    drain();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(i));
      if (i == DEPTH - 2) begin
        n_checks++;
        if (bus.o_full !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL not_full_at_15: full=%b, expected 0", bus.o_full);
        end
      end
    end
    n_checks++;
    if ({bus.o_full, bus.o_count} !== {1'b1, 5'd16}) begin
      n_errors++;
      $display("[TB] FAIL full_at_16: full=%b count=%0d, expected 1 16", bus.o_full, bus.o_count);
    end
    bus.i_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if ({bus.o_valid, bus.o_data} !== {1'b1, 8'(i)}) begin
        n_errors++;
        $display("[TB] FAIL read_order[%0d]: valid=%b data=%h, expected 1 %h", i, bus.o_valid, bus.o_data, 8'(i));
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_checks++;
    if ({bus.o_empty, bus.o_valid} !== 2'b10) begin
      n_errors++;
      $display("[TB] FAIL empty_after_drain: empty=%b valid=%b, expected 1 0", bus.o_empty, bus.o_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    write_byte(8'hEE);
    n_checks++;
    if ({bus.o_overflow, bus.o_drop_cnt, bus.o_data, bus.o_count} !== {1'b1, 8'd1, 8'h00, 5'd16}) begin
      n_errors++;
      $display("[TB] FAIL drop: ovf=%b drop=%0d head=%h count=%0d, expected 1 1 00 16",
               bus.o_overflow, bus.o_drop_cnt, bus.o_data, bus.o_count);
    end
    bus.i_clr_overflow = 1'b1;
    tick();
    bus.i_clr_overflow = 1'b0;
    n_checks++;
    if ({bus.o_overflow, bus.o_drop_cnt, bus.o_count} !== {1'b0, 8'd0, 5'd16}) begin
      n_errors++;
      $display("[TB] FAIL clear: ovf=%b drop=%0d count=%0d, expected 0 0 16",
               bus.o_overflow, bus.o_drop_cnt, bus.o_count);
    end
    bus.i_rx_data = 8'h77;
    bus.i_rx_done = 1'b1;
    bus.i_ready   = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_ready   = 1'b0;
    tick();
    n_checks++;
    if ({bus.o_count, bus.o_overflow, bus.o_data} !== {5'd16, 1'b0, 8'h01}) begin
      n_errors++;
      $display("[TB] FAIL full_push_pop: count=%0d ovf=%b head=%h, expected 16 0 01",
               bus.o_count, bus.o_overflow, bus.o_data);
    end
    write_byte(8'h11);
    write_byte(8'h22);
    bus.i_rx_data      = 8'h33;
    bus.i_rx_done      = 1'b1;
    bus.i_clr_overflow = 1'b1;
    tick();
    bus.i_rx_done      = 1'b0;
    bus.i_clr_overflow = 1'b0;
    tick();
    n_checks++;
    if ({bus.o_overflow, bus.o_drop_cnt} !== {1'b1, 8'd1}) begin
      n_errors++;
      $display("[TB] FAIL clear_vs_drop: ovf=%b drop=%0d, expected 1 1", bus.o_overflow, bus.o_drop_cnt);
    end
    repeat (260) write_byte(8'h44);
    n_checks++;
    if (bus.o_drop_cnt !== 8'd255) begin
      n_errors++;
      $display("[TB] FAIL drop_saturate: drop=%0d, expected 255", bus.o_drop_cnt);
    end
    bus.i_clr_overflow = 1'b1;
    tick();
    bus.i_clr_overflow = 1'b0;
    drain();
  endtask

  task automatic test_watermark();
    bit exp_at_12;
`ifdef UART_RX_FIFO_WATERMARK_EN
    exp_at_12 = 1'b1;
`else
    exp_at_12 = 1'b0;
`endif
    for (int i = 0; i < 11; i++) write_byte(8'($urandom));
    n_checks++;
    if ({bus.o_count, bus.o_afull} !== {5'd11, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL afull_at_11: count=%0d afull=%b, expected 11 0", bus.o_count, bus.o_afull);
    end
    write_byte(8'($urandom));
    n_checks++;
    if ({bus.o_count, bus.o_afull} !== {5'd12, exp_at_12}) begin
      n_errors++;
      $display("[TB] FAIL afull_at_12: count=%0d afull=%b, expected 12 %b", bus.o_count, bus.o_afull, exp_at_12);
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_checks++;
    if ({bus.o_count, bus.o_afull} !== {5'd11, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL afull_after_pop: count=%0d afull=%b, expected 11 0", bus.o_count, bus.o_afull);
    end
    drain();
  endtask

  task automatic test_random_traffic();
    logic [16:0] got;
    logic [16:0] exp;
    bit          bad_seen;
    bad_seen = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.i_rx_data      = 8'($urandom);
      bus.i_rx_done      = 1'($urandom_range(0, 1));
      bus.i_ready        = ((cyc / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.i_clr_overflow = ($urandom_range(0, 31) == 0);
      tick();
      got = {bus.o_valid, bus.o_count, bus.o_full, bus.o_empty, bus.o_overflow, bus.o_drop_cnt, bus.o_afull};
      exp = {byte_q.size() != 0, 5'(byte_q.size()), byte_q.size() == DEPTH, byte_q.size() == 0,
             m_overflow, 8'(m_drop), exp_afull()};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        if (!bad_seen) $display("[TB] FAIL random_flags cycle %0d: got %h, expected %h", cyc, got, exp);
        bad_seen = 1'b1;
      end
      if (byte_q.size() != 0) begin
        n_checks++;
        if (bus.o_data !== byte_q[0]) begin
          n_errors++;
          if (!bad_seen) $display("[TB] FAIL random_data cycle %0d: got %h, expected %h", cyc, bus.o_data, byte_q[0]);
          bad_seen = 1'b1;
        end
      end
    end
    bus.i_rx_done      = 1'b0;
    bus.i_clr_overflow = 1'b1;
    tick();
    bus.i_clr_overflow = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) write_byte(8'($urandom));
    #2;
    i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_valid, bus.o_count, bus.o_overflow, bus.o_empty} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL async_reset: valid=%b count=%0d ovf=%b empty=%b, expected 0 0 0 1",
               bus.o_valid, bus.o_count, bus.o_overflow, bus.o_empty);
    end
    model_clear();
    #3;
    i_reset_n = 1'b1;
    @(posedge i_Clk);
    #1;
    write_byte(8'h5A);
    n_checks++;
    if ({bus.o_count, bus.o_data} !== {5'd1, 8'h5A}) begin
      n_errors++;
      $display("[TB] FAIL after_reset_write: count=%0d data=%h, expected 1 5a", bus.o_count, bus.o_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_held_done();
    test_fill_drain();
    test_overflow();
    test_watermark();
    test_random_traffic();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
